// File: rtl/ila_capture_controller_pkg.sv
// Shared encodings and default widths for the ILA capture controller and its trigger matcher.
// The width macros can be overridden on the command line; depth is always 2**ADDR_WIDTH.
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 10
`endif
`ifndef HOLDOFF_WIDTH
`define HOLDOFF_WIDTH 8
`endif

package ila_capture_controller_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RST     = 3'd1,
    ST_PRIME   = 3'd2,
    ST_ARMED   = 3'd3,
    ST_STOP    = 3'd4,
    ST_DONE    = 3'd5,
    ST_FETCH   = 3'd6,
    ST_PRESENT = 3'd7
  } ila_state_e;

  typedef enum logic [1:0] {
    OP_NOP   = 2'd0,
    OP_ARM   = 2'd1,
    OP_ABORT = 2'd2,
    OP_READ  = 2'd3
  } ila_op_e;

  localparam int ADDR_W = `ADDR_WIDTH;
  localparam int DEPTH  = 1 << ADDR_W;

endpackage

// File: rtl/ila_trigger_match.sv
// Registered mask/value compare of the probe bus plus a one-shot trigger pulse.
// Pulse is combinational from registered state; the one-shot is re-enabled only by clear.
module ila_trigger_match
  import ila_capture_controller_pkg::*;
#(
  parameter int DATA_WIDTH = `DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clear,
  input  logic                  enable,
  input  logic                  auto_hit,
  input  logic [DATA_WIDTH-1:0] probe,
  input  logic [DATA_WIDTH-1:0] mask,
  input  logic [DATA_WIDTH-1:0] value,
  output logic                  pulse
);

  logic match_q;
  logic fired_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      match_q <= 1'b0;
      fired_q <= 1'b0;
    end else begin
      match_q <= ((probe & mask) == (value & mask));
      if (clear) begin
        fired_q <= 1'b0;
      end else if (pulse) begin
        fired_q <= 1'b1;
      end
    end
  end

  assign pulse = enable && !fired_q && (match_q || auto_hit);

endmodule

// File: rtl/ila_capture_controller.sv
// Sequences one ILA capture (reset, prime, trigger, stop) then streams the buffer oldest-first,
// one sample per two cycles at best, holding rd_data/rd_valid while rd_ready is low. ILA_AUTO_TRIG_EN adds a timeout trigger.
module ila_capture_controller
  import ila_capture_controller_pkg::*;
#(
  parameter int DATA_WIDTH    = `DATA_WIDTH,
  parameter int ADDR_WIDTH    = `ADDR_WIDTH,
  parameter int HOLDOFF_WIDTH = `HOLDOFF_WIDTH
`ifdef ILA_AUTO_TRIG_EN
  ,
  parameter int TIMEOUT_WIDTH = 16
`endif
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [1:0]               cmd_op,
  input  logic [HOLDOFF_WIDTH-1:0] cmd_holdoff,
  input  logic [DATA_WIDTH-1:0]    cmd_mask,
  input  logic [DATA_WIDTH-1:0]    cmd_value,
  input  logic [DATA_WIDTH-1:0]    probe,
  output logic                     la_reset,
  output logic                     la_trigger,
  output logic [HOLDOFF_WIDTH-1:0] la_holdoff,
  input  logic                     la_primed,
  input  logic                     la_stopped,
  input  logic [ADDR_WIDTH-1:0]    la_waddr,
  output logic [ADDR_WIDTH-1:0]    la_raddr,
  input  logic [DATA_WIDTH-1:0]    la_rdata,
  output logic                     rd_valid,
  input  logic                     rd_ready,
  output logic [DATA_WIDTH-1:0]    rd_data,
  output logic                     rd_last,
  output logic [2:0]               state,
  output logic                     auto_trig
);

  ila_state_e state_q, state_d;

  logic                     live_q;
  logic                     rst_cnt_q;
  logic                     abort_q;
  logic [HOLDOFF_WIDTH-1:0] holdoff_q;
  logic [DATA_WIDTH-1:0]    mask_q;
  logic [DATA_WIDTH-1:0]    value_q;
  logic [DATA_WIDTH-1:0]    rd_data_q;
  logic [ADDR_WIDTH-1:0]    raddr_q;
  logic [ADDR_WIDTH-1:0]    count_q;

  logic cmd_fire;
  logic arm_go;
  logic abort_go;
  logic read_go;
  logic rd_hs;
  logic trig_pulse;
  logic auto_hit;

  assign cmd_ready = live_q && (state_q != ST_RST);
  assign la_reset  = !live_q || (state_q == ST_RST);
  assign rd_valid  = (state_q == ST_PRESENT);
  assign rd_last   = rd_valid && (&count_q);

  assign cmd_fire = cmd_valid && cmd_ready;
  assign arm_go   = cmd_fire && (cmd_op == OP_ARM) &&
                    ((state_q == ST_IDLE) || (state_q == ST_DONE));
  assign abort_go = cmd_fire && (cmd_op == OP_ABORT);
  assign read_go  = cmd_fire && (cmd_op == OP_READ) && (state_q == ST_DONE);
  // An abort wins over a coincident handshake so the partial stream ends cleanly.
  assign rd_hs    = rd_valid && rd_ready && !abort_go;

  ila_trigger_match #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_trigger_match (
    .clk      (clk),
    .reset    (reset),
    .clear    (arm_go),
    .enable   (state_q == ST_ARMED),
    .auto_hit (auto_hit),
    .probe    (probe),
    .mask     (mask_q),
    .value    (value_q),
    .pulse    (trig_pulse)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (arm_go) state_d = ST_RST;
      ST_RST:     if (rst_cnt_q) state_d = abort_q ? ST_IDLE : ST_PRIME;
      ST_PRIME:   if (la_primed) state_d = ST_ARMED;
      ST_ARMED:   if (trig_pulse) state_d = ST_STOP;
      ST_STOP:    if (la_stopped) state_d = ST_DONE;
      ST_DONE: begin
        if (arm_go) begin
          state_d = ST_RST;
        end else if (read_go) begin
          state_d = ST_FETCH;
        end
      end
      ST_FETCH:   state_d = ST_PRESENT;
      ST_PRESENT: if (rd_hs) state_d = (&count_q) ? ST_IDLE : ST_FETCH;
      default:    state_d = ST_IDLE;
    endcase
    if (abort_go) begin
      state_d = ST_RST;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      live_q    <= 1'b0;
      rst_cnt_q <= 1'b0;
      abort_q   <= 1'b0;
      holdoff_q <= '0;
      mask_q    <= '0;
      value_q   <= '0;
      raddr_q   <= '0;
      count_q   <= '0;
      rd_data_q <= '0;
    end else begin
      live_q    <= 1'b1;
      state_q   <= state_d;
      // Two-cycle core reset: counter is 0 on entry and 1 on the final RST cycle.
      rst_cnt_q <= (state_q == ST_RST) && !rst_cnt_q;

      if (abort_go) begin
        abort_q <= 1'b1;
      end else if ((state_q == ST_RST) && rst_cnt_q) begin
        abort_q <= 1'b0;
      end

      if (arm_go) begin
        holdoff_q <= cmd_holdoff;
        mask_q    <= cmd_mask;
        value_q   <= cmd_value;
      end

      if (read_go) begin
        raddr_q <= la_waddr;
        count_q <= '0;
      end else if (rd_hs) begin
        raddr_q <= raddr_q + 1'b1;
        count_q <= count_q + 1'b1;
      end

      if (state_q == ST_FETCH) begin
        rd_data_q <= la_rdata;
      end
    end
  end

`ifdef ILA_AUTO_TRIG_EN
  logic [TIMEOUT_WIDTH-1:0] to_cnt_q;
  logic                     auto_q;

  // Counter restarts on every ARMED entry and saturates at all-ones, which is the expiry.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      to_cnt_q <= '0;
      auto_q   <= 1'b0;
    end else begin
      if (state_q != ST_ARMED) begin
        to_cnt_q <= '0;
      end else if (!auto_hit) begin
        to_cnt_q <= to_cnt_q + 1'b1;
      end
      if (arm_go) begin
        auto_q <= 1'b0;
      end else if (trig_pulse && auto_hit) begin
        auto_q <= 1'b1;
      end
    end
  end

  assign auto_hit  = &to_cnt_q;
  assign auto_trig = auto_q;
`else
  assign auto_hit  = 1'b0;
  assign auto_trig = 1'b0;
`endif

  assign la_trigger = trig_pulse;
  assign la_holdoff = holdoff_q;
  assign la_raddr   = raddr_q;
  assign rd_data    = rd_data_q;
  assign state      = state_q;

endmodule

// File: tb/tb_ila_capture_controller.sv
// Bench for ila_capture_controller: scripted capture core, scoreboard of expected readout beats.
module tb_ila_capture_controller;
  import ila_capture_controller_pkg::*;

  localparam int DW = 8;
  localparam int AW = 10;
  localparam int HW = 8;
  localparam int DEP = 1 << AW;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [1:0]    cmd_op = 2'd0;
  logic [HW-1:0] cmd_holdoff = '0;
  logic [DW-1:0] cmd_mask = '0;
  logic [DW-1:0] cmd_value = '0;
  logic [DW-1:0] probe = '0;
  logic          la_reset;
  logic          la_trigger;
  logic [HW-1:0] la_holdoff;
  logic          la_primed = 1'b0;
  logic          la_stopped = 1'b0;
  logic [AW-1:0] la_waddr = '0;
  logic [AW-1:0] la_raddr;
  logic [DW-1:0] la_rdata;
  logic          rd_valid;
  logic          rd_ready = 1'b0;
  logic [DW-1:0] rd_data;
  logic          rd_last;
  logic [2:0]    state;
  logic          auto_trig;

  logic [DW-1:0] mem [DEP];
  assign la_rdata = mem[la_raddr];

  typedef struct packed {
    logic [DW-1:0] data;
    logic          last;
    logic [AW-1:0] addr;
  } beat_t;
  beat_t sb[$];

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ila_capture_controller #(
    .DATA_WIDTH    (DW),
    .ADDR_WIDTH    (AW),
    .HOLDOFF_WIDTH (HW)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_op      (cmd_op),
    .cmd_holdoff (cmd_holdoff),
    .cmd_mask    (cmd_mask),
    .cmd_value   (cmd_value),
    .probe       (probe),
    .la_reset    (la_reset),
    .la_trigger  (la_trigger),
    .la_holdoff  (la_holdoff),
    .la_primed   (la_primed),
    .la_stopped  (la_stopped),
    .la_waddr    (la_waddr),
    .la_raddr    (la_raddr),
    .la_rdata    (la_rdata),
    .rd_valid    (rd_valid),
    .rd_ready    (rd_ready),
    .rd_data     (rd_data),
    .rd_last     (rd_last),
    .state       (state),
    .auto_trig   (auto_trig)
  );

  // All tasks are entered and left on a falling edge.
  task automatic send_cmd(input logic [1:0] op, input logic [HW-1:0] hold,
                          input logic [DW-1:0] mask, input logic [DW-1:0] value);
    int n = 0;
    cmd_op = op; cmd_holdoff = hold; cmd_mask = mask; cmd_value = value;
    cmd_valid = 1'b1;
    while (cmd_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (cmd_ready !== 1'b1) begin
      failures++;
      $display("FAIL cmd_accept: op=%0d cmd_ready=%b after %0d cycles, required 1", op, cmd_ready, n);
    end
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_op = 2'd0;
  endtask

  task automatic wait_state(input logic [2:0] s, input string what);
    int n = 0;
    while (state !== s && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (state !== s) begin
      failures++;
      $display("FAIL wait_%s: state=%0d, required %0d", what, state, s);
    end
  endtask

  task automatic count_la_reset(input string what);
    int n = 0;
    while (la_reset === 1'b1 && n < 10) begin
      n++;
      @(negedge clk);
    end
    checks++;
    if (n != 2) begin
      failures++;
      $display("FAIL %s_la_reset_len: %0d cycles, required 2", what, n);
    end
  endtask

  task automatic goto_done(input logic [DW-1:0] mask, input logic [DW-1:0] value,
                           input logic [DW-1:0] hit);
    probe = hit; la_primed = 1'b0; la_stopped = 1'b0;
    send_cmd(OP_ARM, 8'd3, mask, value);
    wait_state(ST_PRIME, "prime");
    la_primed = 1'b1;
    wait_state(ST_STOP, "stop");
    la_stopped = 1'b1;
    wait_state(ST_DONE, "done");
    la_stopped = 1'b0; la_primed = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if ({state, la_reset, la_trigger, rd_valid, rd_last, la_raddr, rd_data, la_holdoff, cmd_ready}
        !== {3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 10'd0, 8'd0, 8'd0, 1'b0}) begin
      failures++;
      $display("FAIL reset_values: state=%0d la_reset=%b trig=%b vld=%b last=%b raddr=%h data=%h hold=%h rdy=%b",
               state, la_reset, la_trigger, rd_valid, rd_last, la_raddr, rd_data, la_holdoff, cmd_ready);
    end
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if ({cmd_ready, la_reset} !== 2'b10) begin
      failures++;
      $display("FAIL after_release: cmd_ready=%b la_reset=%b, required 1 0", cmd_ready, la_reset);
    end
  endtask

  task automatic test_arm_trigger();
    logic [HW-1:0] holds [3] = '{8'd4, 8'd9, 8'd2};
    logic [DW-1:0] masks [3] = '{8'hFF, 8'h0F, 8'hF0};
    logic [DW-1:0] vals  [3] = '{8'h5A, 8'hA5, 8'h3C};
    logic [DW-1:0] miss  [3] = '{8'h00, 8'hA4, 8'h4C};
    logic [DW-1:0] hits  [3] = '{8'h5A, 8'h35, 8'h3A};
    for (int p = 0; p < 3; p++) begin
      int pulses;
      probe = miss[p]; la_primed = 1'b0; la_stopped = 1'b0;
      send_cmd(OP_ARM, holds[p], masks[p], vals[p]);
      count_la_reset("arm");
      checks++;
      if ({state, la_holdoff} !== {ST_PRIME, holds[p]}) begin
        failures++;
        $display("FAIL arm_prime[%0d]: state=%0d holdoff=%h, required %0d %h", p, state, la_holdoff, ST_PRIME, holds[p]);
      end
      la_stopped = 1'b1;
      @(negedge clk);
      la_stopped = 1'b0;
      @(negedge clk);
      checks++;
      if (state !== ST_PRIME) begin
        failures++;
        $display("FAIL stopped_in_prime[%0d]: state=%0d, required %0d", p, state, ST_PRIME);
      end
      la_primed = 1'b1;
      @(negedge clk);
      la_stopped = 1'b1;
      pulses = 0;
      repeat (4) begin
        if (la_trigger === 1'b1) pulses++;
        @(negedge clk);
      end
      la_stopped = 1'b0;
      checks++;
      if (state !== ST_ARMED || pulses != 0) begin
        failures++;
        $display("FAIL armed_no_match[%0d]: state=%0d pulses=%0d, required %0d 0", p, state, pulses, ST_ARMED);
      end
      probe = hits[p];
      pulses = 0;
      repeat (6) begin
        @(negedge clk);
        if (la_trigger === 1'b1) pulses++;
      end
      checks++;
      if (state !== ST_STOP || pulses != 1) begin
        failures++;
        $display("FAIL trigger_once[%0d]: state=%0d pulses=%0d, required %0d 1", p, state, pulses, ST_STOP);
      end
      la_stopped = 1'b1;
      @(negedge clk);
      la_stopped = 1'b0; la_primed = 1'b0;
      checks++;
      if (state !== ST_DONE) begin
        failures++;
        $display("FAIL done[%0d]: state=%0d, required %0d", p, state, ST_DONE);
      end
    end
  endtask

  task automatic test_mask_zero();
    probe = 8'h00; la_primed = 1'b0;
    send_cmd(OP_ARM, 8'd1, 8'h00, 8'hFF);
    wait_state(ST_PRIME, "mz_prime");
    la_primed = 1'b1;
    @(negedge clk);
    checks++;
    if ({state, la_trigger} !== {ST_ARMED, 1'b1}) begin
      failures++;
      $display("FAIL mask_zero_trig: state=%0d trig=%b, required %0d 1", state, la_trigger, ST_ARMED);
    end
    @(negedge clk);
    checks++;
    if ({state, la_trigger} !== {ST_STOP, 1'b0}) begin
      failures++;
      $display("FAIL mask_zero_stop: state=%0d trig=%b, required %0d 0", state, la_trigger, ST_STOP);
    end
    la_stopped = 1'b1;
    wait_state(ST_DONE, "mz_done");
    la_stopped = 1'b0; la_primed = 1'b0;
  endtask

  task automatic test_readout();
    int beats = 0;
    int cyc = 0;
    int stall = 0;
    beat_t exp;
    logic [AW-1:0] a;
    for (int i = 0; i < DEP; i++) mem[i] = DW'($urandom);
    la_waddr = 10'h3FE;
    sb.delete();
    for (int k = 0; k < DEP; k++) begin
      a = la_waddr + AW'(k);
      sb.push_back('{data: mem[a], last: (k == DEP - 1), addr: a});
    end
    rd_ready = 1'b0;
    send_cmd(OP_READ, 8'd0, 8'd0, 8'd0);
    checks++;
    if (state !== ST_FETCH) begin
      failures++;
      $display("FAIL read_fetch: state=%0d, required %0d", state, ST_FETCH);
    end
    while (sb.size() > 0 && cyc < 10000) begin
      if (rd_valid === 1'b1) begin
        exp = sb[0];
        checks++;
        if ({rd_data, rd_last, la_raddr} !== {exp.data, exp.last, exp.addr}) begin
          failures++;
          $display("FAIL beat[%0d]: data=%h last=%b raddr=%h, required %h %b %h",
                   beats, rd_data, rd_last, la_raddr, exp.data, exp.last, exp.addr);
        end
        if (beats == 5 && stall < 5) begin
          rd_ready = 1'b0;
          stall++;
        end else begin
          rd_ready = 1'b1;
          void'(sb.pop_front());
          beats++;
        end
      end else begin
        rd_ready = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    rd_ready = 1'b0;
    checks++;
    if (beats != DEP || stall != 5) begin
      failures++;
      $display("FAIL read_beats: beats=%0d stall=%0d, required %0d 5", beats, stall, DEP);
    end
    checks++;
    if ({state, rd_valid, rd_last} !== {ST_IDLE, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL read_end: state=%0d vld=%b last=%b, required %0d 0 0", state, rd_valid, rd_last, ST_IDLE);
    end
  endtask

  task automatic test_abort();
    int n = 0;
    probe = 8'h00; la_primed = 1'b0;
    send_cmd(OP_ARM, 8'd5, 8'hFF, 8'h5A);
    wait_state(ST_PRIME, "ab_prime");
    la_primed = 1'b1;
    wait_state(ST_ARMED, "ab_armed");
    send_cmd(OP_ABORT, 8'd0, 8'd0, 8'd0);
    count_la_reset("abort_armed");
    checks++;
    if (state !== ST_IDLE) begin
      failures++;
      $display("FAIL abort_armed_idle: state=%0d, required %0d", state, ST_IDLE);
    end
    goto_done(8'h00, 8'h00, 8'h00);
    la_waddr = 10'h100;
    send_cmd(OP_READ, 8'd0, 8'd0, 8'd0);
    rd_ready = 1'b1;
    repeat (6) @(negedge clk);
    rd_ready = 1'b0;
    while (rd_valid !== 1'b1 && n < 10) begin
      @(negedge clk);
      n++;
    end
    send_cmd(OP_ABORT, 8'd0, 8'd0, 8'd0);
    checks++;
    if ({state, rd_valid} !== {ST_RST, 1'b0}) begin
      failures++;
      $display("FAIL abort_present: state=%0d vld=%b, required %0d 0", state, rd_valid, ST_RST);
    end
    count_la_reset("abort_present");
    checks++;
    if ({state, rd_valid} !== {ST_IDLE, 1'b0}) begin
      failures++;
      $display("FAIL abort_present_idle: state=%0d vld=%b, required %0d 0", state, rd_valid, ST_IDLE);
    end
  endtask

  task automatic test_reset_mid_read();
    goto_done(8'hFF, 8'h5A, 8'h5A);
    la_waddr = 10'h000;
    send_cmd(OP_READ, 8'd0, 8'd0, 8'd0);
    rd_ready = 1'b1;
    repeat (7) @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if ({state, la_reset, la_trigger, rd_valid, rd_last, la_raddr, rd_data, la_holdoff, cmd_ready}
        !== {3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 10'd0, 8'd0, 8'd0, 1'b0}) begin
      failures++;
      $display("FAIL async_reset: state=%0d la_reset=%b trig=%b vld=%b last=%b raddr=%h data=%h hold=%h rdy=%b",
               state, la_reset, la_trigger, rd_valid, rd_last, la_raddr, rd_data, la_holdoff, cmd_ready);
    end
    rd_ready = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_release_ready: cmd_ready=%b, required 1", cmd_ready);
    end
    goto_done(8'hFF, 8'h5A, 8'h5A);
    checks++;
    if ({state, la_holdoff} !== {ST_DONE, 8'd3}) begin
      failures++;
      $display("FAIL rearm_after_reset: state=%0d holdoff=%h, required %0d 03", state, la_holdoff, ST_DONE);
    end
  endtask

  initial begin
    test_reset();
    test_arm_trigger();
    test_mask_zero();
    test_readout();
    test_abort();
    test_reset_mid_read();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

endmodule
